// File: rtl/debounce_pkg.sv
// Shared types and default constants for the button debounce arbiter.
// Optional release-event support is controlled by RELEASE_EVENT_EN in the top.
package debounce_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        EMIT   = 2'd2
    } state_t;

    localparam int SETTLE_CYCLES_DEFAULT = 10000;
    localparam int CNT_W_DEFAULT         = 17;

    // Index is sized for the largest supported button count (16).
    typedef struct packed {
        logic [3:0] idx;
        logic       press;
    } evt_t;

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer with asynchronous active-low reset.
module sync_2ff (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/button_debounce_arbiter.sv
// Debounces N buttons with one shared settle counter granted round-robin.
// Define RELEASE_EVENT_EN to also emit events (evt_press=0) on releases.
module button_debounce_arbiter
    import debounce_pkg::*;
#(
    parameter int N_BUTTONS     = 4,
    parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEFAULT,
    parameter int CNT_W         = CNT_W_DEFAULT,
    parameter int IDX_W         = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [N_BUTTONS-1:0] buttons,
    output logic                 evt_valid,
    input  logic                 evt_ready,
    output logic [IDX_W-1:0]     evt_idx,
    output logic                 evt_press,
    output logic [N_BUTTONS-1:0] stable,
    output logic                 busy
);

    state_t               state;
    logic [N_BUTTONS-1:0] sync;
    logic [N_BUTTONS-1:0] pend;
    logic [CNT_W-1:0]     counter;
    logic [IDX_W-1:0]     rr_ptr;
    logic [IDX_W-1:0]     cand_idx;
    logic [IDX_W-1:0]     cand_next;
    logic                 cand_lvl;
    logic                 grant_hit;
    logic [IDX_W-1:0]     grant_idx;

    for (genvar g = 0; g < N_BUTTONS; g++) begin : g_sync
        sync_2ff u_sync (
            .clk     (clk),
            .reset_n (reset_n),
            .d       (buttons[g]),
            .q       (sync[g])
        );
    end

    assign pend      = sync ^ stable;
    assign cand_next = (int'(cand_idx) == N_BUTTONS - 1) ? '0 : cand_idx + 1'b1;

    // Scanning downward lets the closest pending index at/after rr_ptr win.
    always_comb begin
        grant_hit = 1'b0;
        grant_idx = '0;
        for (int k = N_BUTTONS - 1; k >= 0; k--) begin
            if (pend[(int'(rr_ptr) + k) % N_BUTTONS]) begin
                grant_hit = 1'b1;
                grant_idx = IDX_W'((int'(rr_ptr) + k) % N_BUTTONS);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            counter   <= '0;
            rr_ptr    <= '0;
            cand_idx  <= '0;
            cand_lvl  <= 1'b0;
            stable    <= '0;
            evt_valid <= 1'b0;
            evt_idx   <= '0;
            evt_press <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_hit) begin
                        cand_idx <= grant_idx;
                        cand_lvl <= sync[grant_idx];
                        counter  <= '0;
                        state    <= SETTLE;
                        busy     <= 1'b1;
                    end
                end
                SETTLE: begin
                    if (sync[cand_idx] != cand_lvl) begin
                        rr_ptr <= cand_next;
                        state  <= IDLE;
                        busy   <= 1'b0;
                    end else if (counter == CNT_W'(SETTLE_CYCLES - 1)) begin
                        stable[cand_idx] <= cand_lvl;
                        rr_ptr           <= cand_next;
`ifdef RELEASE_EVENT_EN
                        evt_idx   <= cand_idx;
                        evt_press <= cand_lvl;
                        evt_valid <= 1'b1;
                        state     <= EMIT;
`else
                        // Releases commit silently; only presses become events.
                        if (cand_lvl) begin
                            evt_idx   <= cand_idx;
                            evt_press <= 1'b1;
                            evt_valid <= 1'b1;
                            state     <= EMIT;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
`endif
                    end else begin
                        counter <= counter + 1'b1;
                    end
                end
                EMIT: begin
                    if (evt_ready) begin
                        evt_valid <= 1'b0;
                        state     <= IDLE;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_button_debounce_arbiter.sv
// Scoreboard bench for button_debounce_arbiter with SETTLE_CYCLES=16, N_BUTTONS=4.
module tb_button_debounce_arbiter;

    localparam int N = 4;
    localparam int S = 16;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] buttons;
    logic       evt_valid;
    logic       evt_ready;
    logic [1:0] evt_idx;
    logic       evt_press;
    logic [3:0] stable;
    logic       busy;

    typedef struct {
        int idx;
        int press;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad = 0;
    int   hs_count = 0;
    int   cycle = 0;
    int   last_hs_cycle = 0;
    int   prev_hs_cycle = 0;
    int   hs_target;
    int   waited;

    button_debounce_arbiter #(
        .N_BUTTONS     (N),
        .SETTLE_CYCLES (S),
        .CNT_W         (5),
        .IDX_W         (2)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .buttons   (buttons),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_idx   (evt_idx),
        .evt_press (evt_press),
        .stable    (stable),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle++;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input logic [3:0] b);
        buttons = b;
    endtask

    task automatic expect_event(input int idx, input int press);
        exp_t e;
        e.idx   = idx;
        e.press = press;
        exp_q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_handshakes(input string name, input int target, input int limit);
        waited = 0;
        while (hs_count < target && waited < limit) begin
            tick(1);
            waited++;
        end
        check_output(name, hs_count, target);
    endtask

    // Monitor: every accepted event is matched against the head of the scoreboard.
    always @(negedge clk) begin
        if (reset_n && evt_valid && evt_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected_event: got idx=%0d press=%0d, expected none", evt_idx, evt_press);
            end else begin
                mon_e = exp_q.pop_front();
                check_output("evt_idx", 32'(evt_idx), mon_e.idx);
                check_output("evt_press", 32'(evt_press), mon_e.press);
            end
            prev_hs_cycle = last_hs_cycle;
            last_hs_cycle = cycle;
            hs_count++;
        end
    end

    initial begin
        reset_n   = 1'b0;
        evt_ready = 1'b1;
        apply_stimulus(4'b0000);
        tick(2);
        check_output("rst_evt_valid", 32'(evt_valid), 0);
        check_output("rst_stable", 32'(stable), 0);
        check_output("rst_busy", 32'(busy), 0);
        check_output("rst_evt_idx", 32'(evt_idx), 0);
        check_output("rst_evt_press", 32'(evt_press), 0);
        reset_n = 1'b1;
        tick(2);

        // Clean press: stable rises exactly 2+1+16 edges after the input change.
        apply_stimulus(4'b0100);
        expect_event(2, 1);
        tick(S + 2);
        check_output("press_stable_early", 32'(stable[2]), 0);
        tick(1);
        check_output("press_stable_commit", 32'(stable[2]), 1);
        check_output("press_evt_valid", 32'(evt_valid), 1);
        check_output("press_busy", 32'(busy), 1);
        tick(1);
        check_output("press_valid_drop", 32'(evt_valid), 0);
        check_output("press_hs_count", hs_count, 1);

        // Bounce on button 1 every 5 cycles, then hold high.
        for (int i = 0; i < 12; i++) begin
            buttons[1] = (i % 2 == 0);
            tick(5);
        end
        check_output("bounce_no_event", hs_count, 1);
        check_output("bounce_stable", 32'(stable[1]), 0);
        buttons[1] = 1'b1;
        expect_event(1, 1);
        wait_handshakes("bounce_event", 2, 40);
        check_output("bounce_stable_final", 32'(stable), 32'b0110);

        // Release everything, then reset so the pointer restarts at 0.
        apply_stimulus(4'b0000);
`ifdef RELEASE_EVENT_EN
        expect_event(2, 0);
        expect_event(1, 0);
`endif
        tick(60);
        reset_n = 1'b0;
        tick(2);
        reset_n = 1'b1;
        tick(2);

        // Simultaneous press of 0 and 3: served in round-robin order.
        hs_target = hs_count + 2;
        apply_stimulus(4'b1001);
        expect_event(0, 1);
        expect_event(3, 1);
        wait_handshakes("simul_events", hs_target, 100);
        check_output("simul_gap", 32'((last_hs_cycle - prev_hs_cycle) >= S + 1), 1);

        // Backpressure: event must be held while evt_ready is low.
        evt_ready = 1'b0;
        apply_stimulus(4'b1101);
        expect_event(2, 1);
        waited = 0;
        while (!evt_valid && waited < 40) begin
            tick(1);
            waited++;
        end
        check_output("bp_valid_seen", 32'(evt_valid), 1);
        hs_target = hs_count;
        for (int i = 0; i < 50; i++) begin
            tick(1);
            check_output("bp_hold_valid", 32'(evt_valid), 1);
            check_output("bp_hold_idx", 32'(evt_idx), 2);
            check_output("bp_hold_busy", 32'(busy), 1);
        end
        evt_ready = 1'b1;
        tick(1);
        check_output("bp_valid_drop", 32'(evt_valid), 0);
        tick(3);
        check_output("bp_one_handshake", hs_count, hs_target + 1);
        check_output("bp_idle_busy", 32'(busy), 0);

        // Press then release button 1.
        apply_stimulus(4'b1111);
        expect_event(1, 1);
        tick(25);
        check_output("rel_pressed", 32'(stable), 32'b1111);
        apply_stimulus(4'b1101);
`ifdef RELEASE_EVENT_EN
        expect_event(1, 0);
`endif
        tick(25);
        check_output("rel_stable", 32'(stable), 32'b1101);

        // Asynchronous reset in the middle of a settle window.
        apply_stimulus(4'b1111);
        tick(10);
        check_output("arst_busy_before", 32'(busy), 1);
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check_output("arst_evt_valid", 32'(evt_valid), 0);
        check_output("arst_stable", 32'(stable), 0);
        check_output("arst_busy", 32'(busy), 0);
        tick(2);
        reset_n = 1'b1;
        hs_target = hs_count + 4;
        expect_event(0, 1);
        expect_event(1, 1);
        expect_event(2, 1);
        expect_event(3, 1);
        tick(S + 2);
        check_output("arst_restart_early", 32'(stable), 0);
        tick(1);
        check_output("arst_restart_commit", 32'(stable), 32'b0001);
        wait_handshakes("arst_events", hs_target, 150);
        check_output("scoreboard_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
